ifetch_responder: RTL
=====================

Name: ifetch_responder

Overview:
- Memory-side responder for the frontend fetch request interface: accepts one fetch request (pc_index_valid/pc_index_ready handshake) and reads one 128-bit fetch group from a 64-bit backing memory port in two beats.
- Returns the assembled group on pc_read_inst with a single-cycle pc_operation_done pulse.
- Sits between the IFU's pc_ctrl request port and the DDR/SRAM model.
- Supports redirect flush: an in-flight fetch is drained and its response is dropped.

Parameters:
- ADDR_W, 64, request and memory address width.
- BEAT_W, 64, memory data beat width; fixed at half of the 128-bit fetch width.
- LINE_BYTES, 16, fetch group size in bytes; request address is aligned down to this.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pc_index_valid  in  1  fetch request valid
- pc_index  in  ADDR_W  fetch byte address
- pc_index_ready  out  1  request accepted this cycle when high together with valid
- pc_read_inst  out  128  fetch group; beat0 in [63:0], beat1 in [127:64]
- pc_operation_done  out  1  one-cycle pulse; pc_read_inst is valid
- flush_valid  in  1  redirect; cancels any outstanding fetch
- mem_req_valid  out  1  backing read request
- mem_req_addr  out  ADDR_W  8-byte aligned beat address
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  read data valid; in order, one per request, no backpressure
- mem_resp_data  in  BEAT_W  read data
- fetch_count  out  32  completed (non-flushed) fetches, wraps at 2^32

Behaviour:
- Reset (sync, active-high) forces:
  - state IDLE;
  - pc_read_inst=0, pc_operation_done=0, mem_req_valid=0, fetch_count=0;
  - drop flag=0;
  - pc_index_ready=0 during the reset cycle.
- pc_index_ready = (state==IDLE) & !flush_valid & !reset.
- Accept: pc_index_valid & pc_index_ready.
  - Latch base = {pc_index[ADDR_W-1:4], 4'b0}.
  - Go to REQ_LO.
- States:
  - IDLE -> REQ_LO on accept.
  - REQ_LO: mem_req_valid=1, mem_req_addr=base. On mem_req_ready -> WAIT_LO.
  - WAIT_LO: on mem_resp_valid, latch data into line[63:0] -> REQ_HI.
  - REQ_HI: mem_req_valid=1, mem_req_addr=base+8. On mem_req_ready -> WAIT_HI.
  - WAIT_HI: on mem_resp_valid, latch data into line[127:64] -> DONE.
  - DONE (one cycle): pc_operation_done=1, unless drop is set; then -> IDLE.
- mem_req_valid and mem_req_addr are held stable until mem_req_ready.
- Minimum latency with zero-wait memory: accept at cycle 0, done at cycle 5.
- pc_read_inst updates only on the DONE cycle and holds until the next non-dropped DONE.
- Flush handling:
  - IDLE: no effect; blocks acceptance in the same cycle.
  - REQ_LO before the handshake: abandon, go to IDLE, no memory traffic issued.
  - REQ_LO in the same cycle as mem_req_ready: the request is counted as issued; set drop and continue so the response is drained.
  - WAIT_LO/WAIT_HI: set drop; keep consuming responses.
  - REQ_HI with drop set: skip the second beat; go to IDLE after the beat-0 response has been consumed.
  - Any state with drop set: finish draining all issued requests, go to IDLE, no done pulse.
  - DONE: the pulse is already committed and flush does not suppress it.
- The drop flag clears when the FSM returns to IDLE.
- fetch_count increments on each asserted pc_operation_done.
- Reset mid-operation: abandon immediately; no responses are expected after reset (memory is reset with the same signal).
- A mem_resp_valid in IDLE/REQ_* is a protocol error: ignored; simulation assertion fires.

Decomposition:
- Shared frontend package holds:
  - ICACHE_FETCHWIDTH128_RANGE (127:0);
  - LINE_BYTES and the beat offset constant (8);
  - the state enum (IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, DONE).
- Single module; no sub-module needed.
- The beat assembly register can be an inline always block.

Test Plan:
- Zero-wait memory; request pc_index=0x8000_1004, mem data 0x1111.../0x2222... -> addrs 0x8000_1000 then 0x8000_1008; done at cycle 5; pc_read_inst={0x2222...,0x1111...}; fetch_count=1.
- mem_req_ready held low 3 cycles on each beat -> address and valid stable throughout; done at cycle 11.
- flush_valid in WAIT_LO -> beat-0 response consumed; no beat-1 request; no done; ready high again after the beat-0 response plus 1 cycle; fetch_count unchanged.
- flush_valid in the same cycle as pc_index_valid in IDLE -> pc_index_ready=0; no mem_req_valid; a later request completes normally.
- Back-to-back requests 0x0, 0x10 with valid held high -> second accepted the cycle after DONE; two done pulses; fetch_count=2.
- Reset asserted in WAIT_HI -> next cycle all outputs 0 with state IDLE; pc_index_ready=1 once reset is deasserted.

Source files
------------

// File: rtl/ifetch_responder_pkg.sv
// rtl/ifetch_responder_pkg.sv - shared frontend constants, fetch group type and responder states
// Contents:
//   ICACHE_FETCHWIDTH128_MSB/LSB  bounds of the 128-bit fetch group (127:0)
//   icache_fetchwidth128_t        fetch group vector type
//   LINE_BYTES                    fetch group size in bytes (request alignment)
//   BEAT_OFFSET                   byte offset of the second 64-bit beat
//   fetch_state_t                 responder FSM states
package ifetch_responder_pkg;

   localparam int ICACHE_FETCHWIDTH128_MSB = 127;
   localparam int ICACHE_FETCHWIDTH128_LSB = 0;

   typedef logic [ICACHE_FETCHWIDTH128_MSB:ICACHE_FETCHWIDTH128_LSB] icache_fetchwidth128_t;

   localparam int LINE_BYTES  = 16;
   localparam int BEAT_OFFSET = 8;

   typedef enum logic [2:0] {
      IDLE,
      REQ_LO,
      WAIT_LO,
      REQ_HI,
      WAIT_HI,
      DONE
   } fetch_state_t;

endpackage

// File: rtl/ifetch_responder_if.sv
// rtl/ifetch_responder_if.sv - fetch request and backing memory signals of the fetch responder
// Signals:
//   pc_index_valid/pc_index/pc_index_ready   fetch request handshake
//   pc_read_inst/pc_operation_done           fetch group response (one-cycle pulse)
//   flush_valid                              redirect, cancels the outstanding fetch
//   mem_req_valid/mem_req_addr/mem_req_ready backing memory read request
//   mem_resp_valid/mem_resp_data             backing memory read data, in order, no backpressure
// Modports:
//   slave   the responder
//   master  the IFU side plus the memory model
interface ifetch_responder_if
   import ifetch_responder_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int BEAT_W = 64
) ();

   logic                  pc_index_valid;
   logic [ADDR_W-1:0]     pc_index;
   logic                  pc_index_ready;
   icache_fetchwidth128_t pc_read_inst;
   logic                  pc_operation_done;
   logic                  flush_valid;
   logic                  mem_req_valid;
   logic [ADDR_W-1:0]     mem_req_addr;
   logic                  mem_req_ready;
   logic                  mem_resp_valid;
   logic [BEAT_W-1:0]     mem_resp_data;

   modport slave (
      input  pc_index_valid, pc_index, flush_valid, mem_req_ready, mem_resp_valid, mem_resp_data,
      output pc_index_ready, pc_read_inst, pc_operation_done, mem_req_valid, mem_req_addr
   );

   modport master (
      output pc_index_valid, pc_index, flush_valid, mem_req_ready, mem_resp_valid, mem_resp_data,
      input  pc_index_ready, pc_read_inst, pc_operation_done, mem_req_valid, mem_req_addr
   );

endinterface

// File: rtl/ifetch_responder.sv
// rtl/ifetch_responder.sv - fetch responder: one 128-bit fetch group read as two 64-bit memory beats
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   bus          ifetch_responder_if.slave (fetch request/response, flush, memory port)
//   fetch_count  number of completed (non-flushed) fetches, wraps at 2^32
module ifetch_responder
   import ifetch_responder_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int BEAT_W = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   ifetch_responder_if.slave        bus,
   output logic [31:0]              fetch_count
);

   fetch_state_t          state;
   fetch_state_t          state_next;
   logic                  drop;
   logic                  drop_next;
   logic [ADDR_W-1:0]     base;
   logic [BEAT_W-1:0]     line_lo;
   icache_fetchwidth128_t read_inst;
   logic                  accept;
   logic                  drop_eff;
   logic                  hi_complete;

   assign bus.pc_index_ready    = (state == IDLE) && !bus.flush_valid && !reset;
   assign accept                = bus.pc_index_valid && bus.pc_index_ready;
   // A flush arriving this cycle counts as already dropping for the decisions made this cycle.
   assign drop_eff              = drop || bus.flush_valid;
   assign bus.mem_req_valid     = ((state == REQ_LO) || ((state == REQ_HI) && !drop)) && !reset;
   assign bus.mem_req_addr      = (state == REQ_HI) ? base + ADDR_W'(BEAT_OFFSET) : base;
   assign bus.pc_operation_done = (state == DONE) && !reset;
   assign bus.pc_read_inst      = read_inst;
   assign hi_complete           = (state == WAIT_HI) && bus.mem_resp_valid && !drop_eff;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         drop  <= 1'b0;
      end else begin
         state <= state_next;
         drop  <= drop_next;
      end
   end

   always_comb begin
      state_next = state;
      drop_next  = drop;
      case (state)
         IDLE: begin
            if (accept) state_next = REQ_LO;
         end
         REQ_LO: begin
            // Once the request handshakes its response must be drained even if flushed.
            if (bus.mem_req_ready) begin
               state_next = WAIT_LO;
               if (bus.flush_valid) drop_next = 1'b1;
            end else if (bus.flush_valid) begin
               state_next = IDLE;
            end
         end
         WAIT_LO: begin
            if (bus.flush_valid) drop_next = 1'b1;
            if (bus.mem_resp_valid) state_next = drop_eff ? IDLE : REQ_HI;
         end
         REQ_HI: begin
            if (drop) begin
               state_next = IDLE;
            end else if (bus.mem_req_ready) begin
               state_next = WAIT_HI;
               if (bus.flush_valid) drop_next = 1'b1;
            end else if (bus.flush_valid) begin
               state_next = IDLE;
            end
         end
         WAIT_HI: begin
            if (bus.flush_valid) drop_next = 1'b1;
            if (bus.mem_resp_valid) state_next = drop_eff ? IDLE : DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (state_next == IDLE) drop_next = 1'b0;
   end

   // The response register is loaded with the second beat so the new group is visible
   // exactly in the DONE cycle, and it is left untouched by dropped fetches.
   always_ff @(posedge clock) begin
      if (reset) begin
         base        <= '0;
         line_lo     <= '0;
         read_inst   <= '0;
         fetch_count <= '0;
      end else begin
         if (accept) base <= bus.pc_index & ~ADDR_W'(LINE_BYTES - 1);
         if ((state == WAIT_LO) && bus.mem_resp_valid) line_lo <= bus.mem_resp_data;
         if (hi_complete) read_inst <= {bus.mem_resp_data, line_lo};
         if (state == DONE) fetch_count <= fetch_count + 32'd1;
      end
   end

   resp_only_when_waiting: assert property (@(posedge clock) disable iff (reset)
      bus.mem_resp_valid |-> ((state == WAIT_LO) || (state == WAIT_HI)));

endmodule
